// File: rtl/ddr_axi_pkg.sv
// ddr_axi_pkg
//   Shared types and constants for the DDR AXI responder model:
//   write/read FSM state encodings, AXI response codes and the burst
//   length type. A small helper maps an error flag to a response code.
package ddr_axi_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int BYTES_PER_WORD = 4;

  typedef logic [7:0] burst_len_t;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/ddr_resp_mem.sv
// ddr_resp_mem
//   Simple dual-port word array, 2^MEM_AW x 32 bits, split into four
//   byte lanes so each lane maps onto an ordinary block RAM.
//   Ports:
//     clk, rstn            clock, synchronous active-low reset (read register only)
//     wr_en, wr_idx,       write port; wr_strb selects the bytes written
//     wr_data, wr_strb
//     rd_en, rd_idx        read port; rd_data updates the cycle after rd_en
//     rd_data              registered read data, holds while rd_en is low
//   A read and a write to the same word in one cycle return the old word.
module ddr_resp_mem
  import ddr_axi_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [MEM_AW-1:0] wr_idx,
  input  logic [31:0]       wr_data,
  input  logic [3:0]        wr_strb,
  input  logic              rd_en,
  input  logic [MEM_AW-1:0] rd_idx,
  output logic [31:0]       rd_data
);

  localparam int DEPTH = 1 << MEM_AW;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_rd_q;

      always_ff @(posedge clk) begin
        if (wr_en && wr_strb[gi]) begin
          lane_mem[wr_idx] <= wr_data[8*gi +: 8];
        end
      end

      // Separate process from the write so a same-cycle collision reads
      // the pre-write contents.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          lane_rd_q <= 8'h00;
        end else if (rd_en) begin
          lane_rd_q <= lane_mem[rd_idx];
        end
      end

      assign rd_data[8*gi +: 8] = lane_rd_q;
    end
  endgenerate

endmodule

// File: rtl/ddr_axi_resp_model.sv
// ddr_axi_resp_model
//   AXI-style responder standing in for a DDR controller. Accepts one
//   INCR write burst and one INCR read burst at a time (independently),
//   stores data in an internal byte-enabled array and returns B/R
//   responses. Addresses alias: word index = addr[MEM_AW+1:2].
//   Ports:
//     clk, rstn                          clock, synchronous active-low reset
//     awaddr/awlen/awvalid/awready       write address channel
//     wdata/wstrb/wlast/wvalid/wready    write data channel
//     bresp/bvalid/bready                write response channel
//     araddr/arlen/arvalid/arready       read address channel
//     rdata/rresp/rlast/rvalid/rready    read data channel
//     ddr_ready                          controller ready, sticky until reset
//   Build option: define DDR_RESP_CALIB_EN to hold ddr_ready (and with it
//   awready/arready) low for CALIB_CYCLES cycles after reset release.
//   CALIB_CYCLES only exists when that option is compiled in.
module ddr_axi_resp_model
  import ddr_axi_pkg::*;
#(
  parameter int MEM_AW = 12
`ifdef DDR_RESP_CALIB_EN
  ,
  parameter int CALIB_CYCLES = 64
`endif
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  output logic        ddr_ready
);

  // Write side
  wr_state_e         wr_state_q, wr_state_d;
  logic [MEM_AW-1:0] wr_idx_q, wr_idx_d;
  burst_len_t        wr_len_q, wr_len_d;
  burst_len_t        wr_beat_q, wr_beat_d;
  logic              wr_err_q, wr_err_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              mem_we;
  logic              wr_last_beat;

  // Read side
  rd_state_e         rd_state_q, rd_state_d;
  logic [MEM_AW-1:0] rd_idx_q, rd_idx_d;
  burst_len_t        rd_rem_q, rd_rem_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic              mem_re;
  logic [MEM_AW-1:0] mem_rd_idx;

  logic              ddr_ready_q, ddr_ready_d;

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[31:MEM_AW+2], awaddr[1:0],
                              araddr[31:MEM_AW+2], araddr[1:0]};

  // ------------------------------------------------------------------
  // Controller ready
  // ------------------------------------------------------------------
`ifdef DDR_RESP_CALIB_EN
  localparam int CAL_W = $clog2(CALIB_CYCLES + 1);
  logic [CAL_W-1:0] cal_cnt_q, cal_cnt_d;

  // cal_cnt_q counts edges since release; ready is set on the edge where
  // CALIB_CYCLES edges have elapsed.
  always_comb begin
    cal_cnt_d   = cal_cnt_q;
    ddr_ready_d = ddr_ready_q;
    if (!ddr_ready_q) begin
      cal_cnt_d   = cal_cnt_q + 1'b1;
      ddr_ready_d = (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cal_cnt_q <= '0;
    end else begin
      cal_cnt_q <= cal_cnt_d;
    end
  end
`else
  always_comb begin
    ddr_ready_d = 1'b1;
  end
`endif

  // ------------------------------------------------------------------
  // Write FSM
  // ------------------------------------------------------------------
  assign wr_last_beat = (wr_beat_q == wr_len_q);

  always_comb begin
    wr_state_d = wr_state_q;
    wr_idx_d   = wr_idx_q;
    wr_len_d   = wr_len_q;
    wr_beat_d  = wr_beat_q;
    wr_err_d   = wr_err_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;

    case (wr_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          wr_idx_d   = awaddr[MEM_AW+1:2];
          wr_len_d   = awlen;
          wr_beat_d  = '0;
          wr_err_d   = 1'b0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          // No array writes while reset is asserted.
          mem_we    = rstn;
          wr_idx_d  = wr_idx_q + 1'b1;
          wr_beat_d = wr_beat_q + 8'd1;
          wr_err_d  = wr_err_q | (wlast != wr_last_beat);
          // The burst ends by beat count; wlast only feeds the error flag.
          if (wr_last_beat) begin
            wr_state_d = W_RESP;
            bresp_d    = resp_of(wr_err_d);
          end
        end
      end
      W_RESP: begin
        if (bready && bvalid_q) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase

    // Handshake outputs are registered copies of the next-state decode.
    awready_d = ddr_ready_d && (wr_state_d == W_IDLE);
    wready_d  = (wr_state_d == W_DATA);
    bvalid_d  = (wr_state_d == W_RESP);
  end

  // ------------------------------------------------------------------
  // Read FSM
  // ------------------------------------------------------------------
  // rd_idx_q points at the word to fetch next; rd_rem_q counts beats left
  // after the one currently presented on rdata.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    rd_rem_d   = rd_rem_q;
    rlast_d    = rlast_q;
    mem_re     = 1'b0;
    mem_rd_idx = rd_idx_q;

    case (rd_state_q)
      R_IDLE: begin
        if (arvalid && arready_q) begin
          mem_re     = 1'b1;
          mem_rd_idx = araddr[MEM_AW+1:2];
          rd_idx_d   = araddr[MEM_AW+1:2] + 1'b1;
          rd_rem_d   = arlen;
          rlast_d    = (arlen == 8'd0);
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (!rlast_q) begin
            mem_re   = 1'b1;
            rd_idx_d = rd_idx_q + 1'b1;
            rd_rem_d = rd_rem_q - 8'd1;
            rlast_d  = (rd_rem_q == 8'd1);
          end else begin
            rlast_d    = 1'b0;
            rd_state_d = R_IDLE;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase

    arready_d = ddr_ready_d && (rd_state_d == R_IDLE);
    rvalid_d  = (rd_state_d == R_DATA);
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_state_q  <= W_IDLE;
      wr_idx_q    <= '0;
      wr_len_q    <= '0;
      wr_beat_q   <= '0;
      wr_err_q    <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      rd_state_q  <= R_IDLE;
      rd_idx_q    <= '0;
      rd_rem_q    <= '0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      ddr_ready_q <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_idx_q    <= wr_idx_d;
      wr_len_q    <= wr_len_d;
      wr_beat_q   <= wr_beat_d;
      wr_err_q    <= wr_err_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rd_state_q  <= rd_state_d;
      rd_idx_q    <= rd_idx_d;
      rd_rem_q    <= rd_rem_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      ddr_ready_q <= ddr_ready_d;
    end
  end

  // ------------------------------------------------------------------
  // Storage
  // ------------------------------------------------------------------
  ddr_resp_mem #(
    .MEM_AW (MEM_AW)
  ) u_mem (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (mem_we),
    .wr_idx  (wr_idx_q),
    .wr_data (wdata),
    .wr_strb (wstrb),
    .rd_en   (mem_re),
    .rd_idx  (mem_rd_idx),
    .rd_data (rdata)
  );

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign arready   = arready_q;
  assign rvalid    = rvalid_q;
  assign rlast     = rlast_q;
  assign rresp     = RESP_OKAY;
  assign ddr_ready = ddr_ready_q;

endmodule

// File: tb/tb_ddr_axi_resp_model.sv
// tb_ddr_axi_resp_model
//   Randomised scoreboard bench for ddr_axi_resp_model. Stimulus tasks
//   update a plain word-array reference memory and push expected B/R
//   responses into queues; a negedge monitor pops and compares whatever
//   the DUT presents.
module tb_ddr_axi_resp_model;

  localparam int AW = 12;
`ifdef DDR_RESP_CALIB_EN
  localparam int READY_LAT = 64;
`else
  localparam int READY_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        ddr_ready;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } rbeat_t;

  rbeat_t      exp_r [$];
  logic [1:0]  exp_b [$];
  logic [31:0] ref_mem [1 << AW];
  logic [31:0] w_data_buf [256];
  logic [3:0]  w_strb_buf [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ddr_axi_resp_model #(
    .MEM_AW (AW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .araddr    (araddr),
    .arlen     (arlen),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rvalid    (rvalid),
    .rready    (rready),
    .ddr_ready (ddr_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented R beat (also while stalled, which
  // checks the hold behaviour) and every accepted B response.
  always @(negedge clk) begin
    if (rstn) begin
      if (rvalid) begin
        if (exp_r.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL r_unexpected: got rvalid=1 rdata=0x%08h, expected no beat", rdata);
        end else begin
          check("rdata", rdata, exp_r[0].data);
          check("rlast", {31'd0, rlast}, {31'd0, exp_r[0].last});
          check("rresp", {30'd0, rresp}, 32'd0);
          if (rready) exp_r.delete(0);
        end
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_unexpected: got bresp=%0b, expected no response", bresp);
        end else begin
          check("bresp", {30'd0, bresp}, {30'd0, exp_b[0]});
          exp_b.delete(0);
        end
      end
    end
  end

  // Waits (from 1 time unit after an edge) for the edge where the selected
  // ready/valid is high; returns 1 time unit after that edge.
  task automatic wait_hs(input int which);
    bit s;
    bit done;
    int t;
    done = 1'b0;
    t = 0;
    while (!done && t < 1000) begin
      case (which)
        0:       s = awready;
        1:       s = wready;
        2:       s = arready;
        default: s = bvalid;
      endcase
      @(posedge clk);
      #1;
      t++;
      if (s) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout_%0d: got no handshake, expected one within 1000 cycles", which);
    end
  endtask

  task automatic fill_buf(input int len, input bit rand_strb);
    for (int i = 0; i <= len; i++) begin
      w_data_buf[i] = $urandom();
      w_strb_buf[i] = rand_strb ? 4'($urandom_range(0, 15)) : 4'hF;
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input int err_beat,
                          input int abort_after, input int gap_pct);
    logic [AW-1:0] idx;
    bit aborted;
    idx = addr[AW+1:2];
    aborted = 1'b0;
    if (abort_after < 0) exp_b.push_back((err_beat >= 0) ? 2'b10 : 2'b00);
    $display("WR addr=0x%08h len=%0d err_beat=%0d abort_after=%0d", addr, len, err_beat, abort_after);
    awaddr  = addr;
    awlen   = 8'(len);
    awvalid = 1'b1;
    wait_hs(0);
    awvalid = 1'b0;
    check("aw_to_wready", {31'd0, wready}, 32'd1);
    for (int i = 0; i <= len; i++) begin
      if (!aborted) begin
        if (abort_after >= 0 && i == abort_after) begin
          aborted = 1'b1;
        end else begin
          while (int'($urandom_range(0, 99)) < gap_pct) begin
            @(posedge clk);
            #1;
          end
          wdata  = w_data_buf[i];
          wstrb  = w_strb_buf[i];
          wlast  = (i == len) ^ (i == err_beat);
          wvalid = 1'b1;
          wait_hs(1);
          wvalid = 1'b0;
          wlast  = 1'b0;
          for (int b = 0; b < 4; b++) begin
            if (w_strb_buf[i][b]) ref_mem[idx][8*b +: 8] = w_data_buf[i][8*b +: 8];
          end
          idx = idx + 1'b1;
        end
      end
    end
    if (!aborted) begin
      check("w_to_bvalid", {31'd0, bvalid}, 32'd1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      bready = 1'b1;
      wait_hs(3);
      bready = 1'b0;
    end
  endtask

  // mode 0: rready always high; 1: toggles 1,0,1,0...; 2: random.
  task automatic do_read(input logic [31:0] addr, input int len, input int mode,
                         input int abort_after);
    logic [AW-1:0] idx;
    rbeat_t e;
    int got;
    int cyc;
    bit s;
    idx = addr[AW+1:2];
    for (int i = 0; i <= len; i++) begin
      e.data = ref_mem[idx];
      e.last = (i == len);
      exp_r.push_back(e);
      idx = idx + 1'b1;
    end
    $display("RD addr=0x%08h len=%0d mode=%0d abort_after=%0d", addr, len, mode, abort_after);
    araddr  = addr;
    arlen   = 8'(len);
    arvalid = 1'b1;
    wait_hs(2);
    arvalid = 1'b0;
    check("ar_to_rvalid", {31'd0, rvalid}, 32'd1);
    got = 0;
    cyc = 0;
    while (got <= len && cyc < 2000 && !(abort_after >= 0 && got == abort_after)) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (cyc % 2 == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      s = rvalid && rready;
      @(posedge clk);
      #1;
      cyc++;
      if (s) got++;
    end
    rready = 1'b0;
    if (cyc >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL read_timeout: got %0d beats, expected %0d", got, len + 1);
    end
  endtask

  task automatic release_reset();
    int k;
    bit early;
    bit up;
    rstn  = 1'b1;
    early = 1'b0;
    up    = 1'b0;
    k     = 0;
    check("ddr_ready_in_reset", {31'd0, ddr_ready}, 32'd0);
    while (!up && k < READY_LAT + 5) begin
      @(posedge clk);
      #1;
      k++;
      if (ddr_ready) up = 1'b1;
      else if (awready || arready) early = 1'b1;
    end
    check("ready_latency", k, READY_LAT);
    check("ready_gating", {31'd0, early}, 32'd0);
    check("awready_up", {31'd0, awready}, 32'd1);
    check("arready_up", {31'd0, arready}, 32'd1);
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rlast", {31'd0, rlast}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    exp_r.delete();
    exp_b.delete();
  endtask

  initial begin
    rstn    = 1'b0;
    awaddr  = '0;
    awlen   = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wlast   = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    araddr  = '0;
    arlen   = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {22'd0, awready, wready, bvalid, arready, rvalid, rlast,
                            ddr_ready, bresp, rresp[0]}, 32'd0);
    check("reset_resp", {28'd0, bresp, rresp}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    release_reset();

    // Give the whole array known contents.
    for (int blk = 0; blk < (1 << AW) / 256; blk++) begin
      fill_buf(255, 1'b0);
      do_write(32'(blk * 1024), 255, -1, -1, 0);
    end

    // Single write then read.
    w_data_buf[0] = 32'h8765_4321;
    w_strb_buf[0] = 4'hF;
    do_write(32'h8f00_f000, 0, -1, -1, 0);
    do_read(32'h8f00_f000, 0, 0, -1);

    // Burst write, stalled burst read.
    for (int i = 0; i < 4; i++) begin
      w_data_buf[i] = 32'h1111_1111 * (i + 1);
      w_strb_buf[i] = 4'hF;
    end
    do_write(32'h0000_0100, 3, -1, -1, 20);
    do_read(32'h0000_0100, 3, 1, -1);

    // Byte strobes over a zeroed word.
    w_data_buf[0] = 32'h0000_0000;
    w_strb_buf[0] = 4'hF;
    do_write(32'h0000_0200, 0, -1, -1, 0);
    w_data_buf[0] = 32'hAABB_CCDD;
    w_strb_buf[0] = 4'b0101;
    do_write(32'h0000_0200, 0, -1, -1, 0);
    do_read(32'h0000_0200, 0, 0, -1);

    // Index wrap, including ignored upper/low address bits.
    fill_buf(1, 1'b0);
    do_write(32'h7000_3FFC, 1, -1, -1, 0);
    do_read(32'h0000_0003, 0, 0, -1);
    do_read(32'hFFFF_FFFC, 1, 2, -1);

    // wlast errors: early wlast, then missing wlast.
    fill_buf(1, 1'b0);
    do_write(32'h0000_0400, 1, 0, -1, 0);
    fill_buf(2, 1'b1);
    do_write(32'h0000_0500, 2, 2, -1, 0);
    do_read(32'h0000_0400, 1, 0, -1);

    // Randomised traffic, sometimes with both directions in flight.
    for (int it = 0; it < 40; it++) begin
      logic [31:0] wa;
      logic [31:0] ra;
      int wl;
      int rl;
      int eb;
      int sel;
      wa = $urandom();
      wa[13:2] = 12'($urandom_range(0, 1999));
      ra = $urandom();
      ra[13:2] = 12'($urandom_range(2100, 4000));
      wl  = $urandom_range(0, 15);
      rl  = $urandom_range(0, 15);
      eb  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, wl)) : -1;
      sel = $urandom_range(0, 2);
      fill_buf(wl, 1'b1);
      case (sel)
        0: begin
          do_write(wa, wl, eb, -1, 25);
          do_read(wa, wl, $urandom_range(0, 2), -1);
        end
        1: begin
          fork
            do_write(wa, wl, eb, -1, 25);
            do_read(ra, rl, $urandom_range(0, 2), -1);
          join
        end
        default: begin
          ra = $urandom();
          do_read(ra, rl, $urandom_range(0, 2), -1);
        end
      endcase
    end

    // Reset in the middle of a read burst.
    do_read(32'h0000_0800, 7, 0, 3);
    pulse_reset();
    release_reset();

    // Reset in the middle of a write burst: beats already written stay.
    fill_buf(3, 1'b0);
    do_write(32'h0000_0900, 3, -1, 2, 0);
    pulse_reset();
    release_reset();
    do_read(32'h0000_0900, 3, 0, -1);

    repeat (20) @(posedge clk);
    #1;
    check("r_queue_drained", exp_r.size(), 0);
    check("b_queue_drained", exp_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_axi_resp_model.md
# ddr_axi_resp_model

Single-port AXI-style responder modelling the DDR controller end of the memory interface, used in place of the real controller in simulation and on small-FPGA bring-up. It accepts write address/data bursts and read address bursts from an initiator, stores data in an internal byte-enabled word array, and returns write responses and read data bursts. It also drives `ddr_ready` so initiators can gate their first transaction.

## Interface
- `MEM_AW`, 12: word-address width of the internal array; depth is 2^MEM_AW 32-bit words.
- `CALIB_CYCLES`, 64: cycles from reset release to `ddr_ready` high, used only when calibration modelling is compiled in.
- `clk` in 1: clock; all logic is on the rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `awaddr` in 32, `awlen` in 8, `awvalid` in 1, `awready` out 1: write address channel.
- `wdata` in 32, `wstrb` in 4, `wlast` in 1, `wvalid` in 1, `wready` out 1: write data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.
- `araddr` in 32, `arlen` in 8, `arvalid` in 1, `arready` out 1: read address channel.
- `rdata` out 32, `rresp` out 2, `rlast` out 1, `rvalid` out 1, `rready` in 1: read data channel.
- `ddr_ready` out 1: controller ready; stays high once set, until the next reset.

## Operation
- Indexing: word index = `addr[MEM_AW+1:2]`. Upper bits and `addr[1:0]` are ignored, so the array aliases across the address space.
- Bursts are INCR only. Beats = len+1. The index increments by 1 per beat and wraps modulo 2^MEM_AW.
- Write FSM states:
  - W_IDLE: `awready` = `ddr_ready`. On `awvalid & awready`, latch the index and len, clear the beat counter and error flag, then go to W_DATA.
  - W_DATA: `wready` = 1. On each `wvalid & wready`, write the bytes enabled by `wstrb` (`wstrb`=0 writes nothing).
    - Error flag sets if `wlast` disagrees with (beat == len).
    - On the beat where beat == len, go to W_RESP.
    - Extra beats after an early `wlast` are not possible, because the burst ends by count.
  - W_RESP: `bvalid` = 1, `bresp` = SLVERR if the error flag is set, else OKAY. On `bready`, go to W_IDLE.
- Read FSM states:
  - R_IDLE: `arready` = `ddr_ready`. On `arvalid & arready`, load `rdata` with mem[index], set `rvalid`, set `rlast` = (arlen==0), then go to R_DATA.
  - R_DATA: `rvalid` = 1, `rresp` = OKAY.
    - On `rready` with `rlast`=0: load the next word and update `rlast`.
    - On `rready` with `rlast`=1: clear `rvalid` and `rlast`, then go to R_IDLE.
    - While `rready`=0, `rdata` and `rlast` hold.
- The read and write FSMs are fully independent. Both may be active at once.

## Timing
- Reset values: `awready`, `wready`, `bvalid`, `arready`, `rvalid`, `rlast`, `ddr_ready` = 0; `bresp`, `rresp` = 0; `rdata` = 0. Memory contents are not reset.
- Reset mid-burst: both FSMs return to idle on the next edge. The partial write keeps the beats already written, and no response is issued.
- Handshake latencies:
  - AW/AR handshake to `wready`/`rvalid`: 1 cycle.
  - Last W beat to `bvalid`: 1 cycle.
  - `bvalid` and `rvalid` are held until accepted.
- Throughput: one read beat per cycle with `rready` held high; one write beat per cycle.
- Read/write collision on the same word in the same cycle: the read returns the old data. Any later read returns the new data.
- A new AW is accepted only in W_IDLE, and a new AR only in R_IDLE. There are no outstanding transactions beyond one per direction.

## Configuration
- `DDR_RESP_CALIB_EN` defined:
  - A counter runs from reset release, and `ddr_ready` rises exactly `CALIB_CYCLES` cycles after `rstn` goes high.
  - Until then `awready` and `arready` stay 0.
- Undefined: `ddr_ready` rises on the first edge with `rstn` high.

## Structure
- Shared package `ddr_axi_pkg`:
  - write-state and read-state enums;
  - response constants `RESP_OKAY` = 2'b00 and `RESP_SLVERR` = 2'b10;
  - burst-length type (8-bit).
- Sub-module `ddr_resp_mem`: simple dual-port array with one byte-enabled write port and one synchronous read port, parameterised by `MEM_AW`.

## Test plan
- Single write then read:
  - Write 0x87654321 to 0x8f00f000 with awlen=0 and `wlast`=1; expect `bresp`=00.
  - Then AR to 0x8f00f000 with arlen=0; expect `rdata`=0x87654321 with `rlast`=1 one cycle after the AR handshake.
- Burst write then burst read:
  - Write data 0x11111111..0x44444444 with awlen=3 at 0x100.
  - Read with arlen=3 and `rready` toggling 1,0,1,0; expect the four words in order, each held through stalls, and `rlast` only on the 4th.
- Strobes: write 0xAABBCCDD with `wstrb`=0101 over a word holding 0x00000000; read back 0x00BB00DD.
- Wrap and `wlast` error:
  - With MEM_AW=12, write awlen=1 at index 4095; the second beat lands at index 0.
  - A separate burst with `wlast`=1 on beat 0 of awlen=1 gives `bresp`=10.
- Reset and calibration:
  - Deassert `rstn` mid-read; expect `rvalid`=0 on the next cycle.
  - With `DDR_RESP_CALIB_EN`, `ddr_ready`, `awready` and `arready` stay 0 for exactly 64 cycles after reset release.
